// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared types and constants for the Clause-22 MDIO responder
// Contents: frame phase enum, opcode values, fixed register indices.
package mdio_pkg;

  typedef enum logic [2:0] {
    PH_PRE,
    PH_ST,
    PH_OP,
    PH_PHYAD,
    PH_REGAD,
    PH_TA,
    PH_DATA
  } ph_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [4:0] REG_CTRL     = 5'd0;
  localparam logic [4:0] REG_STAT     = 5'd1;
  localparam logic [4:0] REG_ID1      = 5'd2;
  localparam logic [4:0] REG_ID2      = 5'd3;
  localparam logic [4:0] REG_STORE_LO = 5'd4;

  // Preamble ones counter saturates here so arbitrarily long preambles still qualify.
  localparam logic [5:0] ONES_MAX = 6'd32;

endpackage

// File: rtl/mdio_edge_sync.sv
// rtl/mdio_edge_sync.sv - 2-flop synchronisers for MDC/MDIO plus MDC rising-edge pulse
// Ports: clk, rst (sync, active-high), mdc, mdio (async in),
//        mdc_rise (1-cycle pulse on synced 0->1 of MDC), mdio_sync (synced MDIO).
module mdio_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  input  logic mdio,
  output logic mdc_rise,
  output logic mdio_sync
);

  logic [1:0] mdc_ff;
  logic [1:0] mdio_ff;
  logic       mdc_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_ff   <= 2'b00;
      mdio_ff  <= 2'b00;
      mdc_prev <= 1'b0;
    end else begin
      mdc_ff   <= {mdc_ff[0], mdc};
      mdio_ff  <= {mdio_ff[0], mdio};
      mdc_prev <= mdc_ff[1];
    end
  end

  assign mdc_rise  = mdc_ff[1] & ~mdc_prev;
  assign mdio_sync = mdio_ff[1];

endmodule

// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - PHY-side Clause-22 MDIO slave with a 32x16 register space
// Ports: clk_rmii, rst (sync, active-high), i_mdc/i_mdio (station in),
//        o_mdio/oe_mdio (responder drive), status_i (live reg 1), ctrl_o (reg 0),
//        phy_soft_rst (pulse on reg 0 bit 15 write), wr_valid/wr_addr/wr_data (write strobe).
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter logic [15:0] PHY_ID1      = 16'h0007,
  parameter logic [15:0] PHY_ID2      = 16'hC0F1,
  parameter logic [15:0] CTRL_RESET   = 16'h3100,
  parameter int          PREAMBLE_LEN = 32
) (
  input  logic        clk_rmii,
  input  logic        rst,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        oe_mdio,
  input  logic [15:0] status_i,
  output logic [15:0] ctrl_o,
  output logic        phy_soft_rst,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_LEN);

  logic        mdc_rise;
  logic        mdio_s;
  ph_e         ph;
  logic [5:0]  ones_cnt;
  logic [3:0]  bit_cnt;
  logic [1:0]  op;
  logic [4:0]  phyad;
  logic [4:0]  regad;
  logic [15:0] shreg;
  logic [15:0] store [4:31];
  logic [15:0] rd_data;
  logic [15:0] wdata;
  logic        hit;

  mdio_edge_sync u_sync (
    .clk       (clk_rmii),
    .rst       (rst),
    .mdc       (i_mdc),
    .mdio      (i_mdio),
    .mdc_rise  (mdc_rise),
    .mdio_sync (mdio_s)
  );

  assign hit = (phyad == PHY_ADDR);
  // Shift register doubles as write collector: the 16th data bit arrives live.
  assign wdata = {shreg[14:0], mdio_s};

  always_comb begin
    rd_data = 16'h0000;
    case (regad)
      REG_CTRL: rd_data = {1'b0, ctrl_o[14:0]};
      REG_STAT: rd_data = status_i;
      REG_ID1:  rd_data = PHY_ID1;
      REG_ID2:  rd_data = PHY_ID2;
      default:  rd_data = store[regad];
    endcase
  end

  always_ff @(posedge clk_rmii) begin
    if (rst) begin
      ph           <= PH_PRE;
      ones_cnt     <= 6'd0;
      bit_cnt      <= 4'd0;
      op           <= 2'b00;
      phyad        <= 5'd0;
      regad        <= 5'd0;
      shreg        <= 16'h0000;
      o_mdio       <= 1'b0;
      oe_mdio      <= 1'b0;
      ctrl_o       <= CTRL_RESET;
      phy_soft_rst <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= 5'd0;
      wr_data      <= 16'h0000;
      for (int i = 4; i < 32; i++) store[i] <= 16'h0000;
    end else begin
      wr_valid     <= 1'b0;
      phy_soft_rst <= 1'b0;
      if (mdc_rise) begin
        case (ph)
          PH_PRE: begin
            if (mdio_s) begin
              if (ones_cnt != ONES_MAX) ones_cnt <= ones_cnt + 6'd1;
            end else if (ones_cnt >= PRE_MIN) begin
              // This 0 is the first start bit.
              ph       <= PH_ST;
              ones_cnt <= 6'd0;
            end else begin
              ones_cnt <= 6'd0;
            end
          end
          PH_ST: begin
            bit_cnt <= 4'd0;
            ph      <= mdio_s ? PH_OP : PH_PRE;
          end
          PH_OP: begin
            op <= {op[0], mdio_s};
            if (bit_cnt == 4'd1) begin
              bit_cnt <= 4'd0;
              if ({op[0], mdio_s} == OP_READ || {op[0], mdio_s} == OP_WRITE) ph <= PH_PHYAD;
              else ph <= PH_PRE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          PH_PHYAD: begin
            phyad <= {phyad[3:0], mdio_s};
            if (bit_cnt == 4'd4) begin
              bit_cnt <= 4'd0;
              ph      <= PH_REGAD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          PH_REGAD: begin
            regad <= {regad[3:0], mdio_s};
            if (bit_cnt == 4'd4) begin
              bit_cnt <= 4'd0;
              ph      <= PH_TA;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          PH_TA: begin
            if (bit_cnt == 4'd0) begin
              // Take the bus during TA so the station sees 0 on the second TA bit.
              if (hit && op == OP_READ) begin
                oe_mdio <= 1'b1;
                o_mdio  <= 1'b0;
              end
              shreg   <= rd_data;
              bit_cnt <= 4'd1;
            end else begin
              o_mdio  <= oe_mdio & shreg[15];
              shreg   <= wdata;
              bit_cnt <= 4'd0;
              ph      <= PH_DATA;
            end
          end
          PH_DATA: begin
            if (bit_cnt == 4'd15) begin
              oe_mdio  <= 1'b0;
              o_mdio   <= 1'b0;
              ph       <= PH_PRE;
              ones_cnt <= 6'd0;
              bit_cnt  <= 4'd0;
              if (hit && op == OP_WRITE) begin
                wr_valid <= 1'b1;
                wr_addr  <= regad;
                wr_data  <= wdata;
                if (regad == REG_CTRL) begin
                  if (wdata[15]) begin
                    ctrl_o       <= CTRL_RESET;
                    phy_soft_rst <= 1'b1;
                  end else begin
                    ctrl_o <= wdata;
                  end
                end else if (regad >= REG_STORE_LO) begin
                  store[regad] <= wdata;
                end
              end
            end else begin
              o_mdio  <= oe_mdio & shreg[15];
              shreg   <= wdata;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: ph <= PH_PRE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// tb/tb_mdio_responder.sv - self-checking bench for mdio_responder
// Drives Clause-22 frames from a bit-banged station model and checks them against a register model.
module tb_mdio_responder;
  import mdio_pkg::*;

  logic        clk_rmii = 1'b0;
  logic        rst;
  logic        i_mdc;
  logic        i_mdio;
  logic        o_mdio;
  logic        oe_mdio;
  logic [15:0] status_i;
  logic [15:0] ctrl_o;
  logic        phy_soft_rst;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int n_cmp = 0;
  int n_fail = 0;
  int wr_pulses = 0;
  int soft_cycles = 0;
  logic [4:0]  last_wr_addr = 5'd0;
  logic [15:0] last_wr_data = 16'h0;

  logic [15:0] m_ctrl;
  logic [15:0] m_store [32];

  always #5 clk_rmii = ~clk_rmii;

  mdio_responder dut (
    .clk_rmii     (clk_rmii),
    .rst          (rst),
    .i_mdc        (i_mdc),
    .i_mdio       (i_mdio),
    .o_mdio       (o_mdio),
    .oe_mdio      (oe_mdio),
    .status_i     (status_i),
    .ctrl_o       (ctrl_o),
    .phy_soft_rst (phy_soft_rst),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  always @(negedge clk_rmii) begin
    if (wr_valid === 1'b1) begin
      wr_pulses++;
      last_wr_addr = wr_addr;
      last_wr_data = wr_data;
    end
    if (phy_soft_rst === 1'b1) soft_cycles++;
  end

  // Register model
  task automatic m_reset();
    m_ctrl = 16'h3100;
    for (int i = 0; i < 32; i++) m_store[i] = 16'h0;
  endtask

  function automatic logic [15:0] m_read(input logic [4:0] r);
    case (r)
      5'd0:    return m_ctrl & 16'h7FFF;
      5'd1:    return status_i;
      5'd2:    return 16'h0007;
      5'd3:    return 16'hC0F1;
      default: return m_store[r];
    endcase
  endfunction

  task automatic m_write(input logic [4:0] r, input logic [15:0] d);
    if (r == 5'd0) m_ctrl = d[15] ? 16'h3100 : d;
    else if (r >= 5'd4) m_store[r] = d;
  endtask

  // One MDC period: station changes MDIO while MDC is low, samples the line just before the rise.
  task automatic mdc_bit(input logic b, output logic oe_s, output logic o_s);
    i_mdc  = 1'b0;
    i_mdio = b;
    repeat (5) @(posedge clk_rmii);
    @(negedge clk_rmii);
    oe_s  = oe_mdio;
    o_s   = o_mdio;
    i_mdc = 1'b1;
    repeat (5) @(negedge clk_rmii);
  endtask

  // Bit 0 is a lone 0 so the preamble length seen is exactly pre; two idle ones trail the frame.
  // Rise index n_last samples the final REGAD bit; TA2 sampled at n_last+2, data at n_last+3..+18.
  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phyad,
                           input logic [4:0] regad, input logic [15:0] wdata, input bit exp_drive,
                           input int stop_after, output logic [15:0] rd, output logic ta_o,
                           output int oe_err, output int wr_n, output int soft_n);
    bit   q[$];
    logic oe_s, o_s, exp_oe;
    int   n_last, w0, s0, lim;
    q.push_back(1'b0);
    repeat (pre) q.push_back(1'b1);
    q.push_back(1'b0);
    q.push_back(1'b1);
    for (int i = 1; i >= 0; i--) q.push_back(op[i]);
    for (int i = 4; i >= 0; i--) q.push_back(phyad[i]);
    for (int i = 4; i >= 0; i--) q.push_back(regad[i]);
    if (op == OP_READ) begin
      repeat (18) q.push_back(1'b1);
    end else begin
      q.push_back(1'b1);
      q.push_back(1'b0);
      for (int i = 15; i >= 0; i--) q.push_back(wdata[i]);
    end
    q.push_back(1'b1);
    q.push_back(1'b1);
    n_last = pre + 14;
    w0 = wr_pulses;
    s0 = soft_cycles;
    rd = 16'h0;
    ta_o = 1'b1;
    oe_err = 0;
    lim = (stop_after < 0) ? q.size() : stop_after;
    for (int k = 0; k < lim; k++) begin
      mdc_bit(q[k], oe_s, o_s);
      exp_oe = exp_drive && (k >= n_last + 2) && (k <= n_last + 18);
      if (oe_s !== exp_oe) oe_err++;
      if (k == n_last + 2) ta_o = o_s;
      if (k >= n_last + 3 && k <= n_last + 18) rd[15 - (k - n_last - 3)] = o_s;
    end
    wr_n = wr_pulses - w0;
    soft_n = soft_cycles - s0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_mdc = 1'b0;
    i_mdio = 1'b1;
    status_i = 16'h796D;
    repeat (4) @(negedge clk_rmii);
    rst = 1'b0;
    m_reset();
    @(negedge clk_rmii);
    n_cmp++; if (oe_mdio !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", oe_mdio); end
    n_cmp++; if (o_mdio !== 1'b0) begin n_fail++; $display("FAIL reset_o: got %b want 0", o_mdio); end
    n_cmp++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
    n_cmp++; if (phy_soft_rst !== 1'b0) begin n_fail++; $display("FAIL reset_soft: got %b want 0", phy_soft_rst); end
    n_cmp++; if (ctrl_o !== m_ctrl) begin n_fail++; $display("FAIL reset_ctrl: got %h want %h", ctrl_o, m_ctrl); end
  endtask

  task automatic test_read_id();
    logic [15:0] rd, exp;
    logic ta;
    int oe_err, wr_n, soft_n;
    exp = m_read(REG_ID1);
    run_frame(32, OP_READ, 5'd1, REG_ID1, 16'h0, 1'b1, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (oe_err !== 0) begin n_fail++; $display("FAIL read_id_oe_window: got %0d bad samples want 0", oe_err); end
    n_cmp++; if (ta !== 1'b0) begin n_fail++; $display("FAIL read_id_ta2: got %b want 0", ta); end
    n_cmp++; if (rd !== exp) begin n_fail++; $display("FAIL read_id_data: got %h want %h", rd, exp); end
    n_cmp++; if (wr_n !== 0) begin n_fail++; $display("FAIL read_id_no_write: got %0d want 0", wr_n); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd;
    logic ta;
    int oe_err, wr_n, soft_n;
    run_frame(32, OP_WRITE, 5'd1, 5'd5, 16'hBEEF, 1'b0, -1, rd, ta, oe_err, wr_n, soft_n);
    m_write(5'd5, 16'hBEEF);
    n_cmp++; if (wr_n !== 1) begin n_fail++; $display("FAIL wr5_pulse: got %0d cycles want 1", wr_n); end
    n_cmp++; if (last_wr_addr !== 5'd5) begin n_fail++; $display("FAIL wr5_addr: got %0d want 5", last_wr_addr); end
    n_cmp++; if (last_wr_data !== 16'hBEEF) begin n_fail++; $display("FAIL wr5_data: got %h want beef", last_wr_data); end
    n_cmp++; if (oe_err !== 0) begin n_fail++; $display("FAIL wr5_no_drive: got %0d bad samples want 0", oe_err); end
    run_frame(32, OP_READ, 5'd1, 5'd5, 16'h0, 1'b1, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (rd !== m_read(5'd5)) begin n_fail++; $display("FAIL rd5_data: got %h want %h", rd, m_read(5'd5)); end
    n_cmp++; if (oe_err !== 0) begin n_fail++; $display("FAIL rd5_oe_window: got %0d bad samples want 0", oe_err); end
  endtask

  task automatic test_soft_reset();
    logic [15:0] rd;
    logic ta;
    int oe_err, wr_n, soft_n;
    run_frame(32, OP_WRITE, 5'd1, REG_CTRL, 16'h1234, 1'b0, -1, rd, ta, oe_err, wr_n, soft_n);
    m_write(REG_CTRL, 16'h1234);
    n_cmp++; if (ctrl_o !== m_ctrl) begin n_fail++; $display("FAIL ctrl_write: got %h want %h", ctrl_o, m_ctrl); end
    n_cmp++; if (soft_n !== 0) begin n_fail++; $display("FAIL ctrl_write_no_soft: got %0d want 0", soft_n); end
    run_frame(32, OP_WRITE, 5'd1, REG_CTRL, 16'h8000, 1'b0, -1, rd, ta, oe_err, wr_n, soft_n);
    m_write(REG_CTRL, 16'h8000);
    n_cmp++; if (soft_n !== 1) begin n_fail++; $display("FAIL soft_pulse: got %0d cycles want 1", soft_n); end
    n_cmp++; if (wr_n !== 1 || last_wr_data !== 16'h8000) begin n_fail++; $display("FAIL soft_wr_strobe: got %0d/%h want 1/8000", wr_n, last_wr_data); end
    n_cmp++; if (ctrl_o !== m_ctrl) begin n_fail++; $display("FAIL soft_ctrl: got %h want %h", ctrl_o, m_ctrl); end
    run_frame(32, OP_READ, 5'd1, REG_CTRL, 16'h0, 1'b1, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (rd !== 16'h3100) begin n_fail++; $display("FAIL soft_rd0: got %h want 3100", rd); end
    run_frame(32, OP_READ, 5'd1, 5'd5, 16'h0, 1'b1, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (rd !== m_read(5'd5)) begin n_fail++; $display("FAIL soft_keeps_rd5: got %h want %h", rd, m_read(5'd5)); end
  endtask

  task automatic test_wrong_phyad();
    logic [15:0] rd;
    logic ta;
    int oe_err, wr_n, soft_n;
    run_frame(32, OP_READ, 5'd3, REG_ID1, 16'h0, 1'b0, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (oe_err !== 0) begin n_fail++; $display("FAIL phyad3_read_drive: got %0d driven samples want 0", oe_err); end
    run_frame(32, OP_WRITE, 5'd3, 5'd5, 16'h0BAD, 1'b0, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (wr_n !== 0) begin n_fail++; $display("FAIL phyad3_write: got %0d want 0", wr_n); end
    run_frame(32, OP_READ, 5'd1, 5'd5, 16'h0, 1'b1, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (rd !== m_read(5'd5) || oe_err !== 0) begin n_fail++; $display("FAIL phyad1_after_miss: got %h/%0d want %h/0", rd, oe_err, m_read(5'd5)); end
  endtask

  task automatic test_bad_frames();
    logic [15:0] rd;
    logic ta;
    int oe_err, wr_n, soft_n;
    run_frame(31, OP_READ, 5'd1, REG_ID1, 16'h0, 1'b0, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (oe_err !== 0) begin n_fail++; $display("FAIL pre31_read_drive: got %0d driven samples want 0", oe_err); end
    run_frame(31, OP_WRITE, 5'd1, 5'd7, 16'h1357, 1'b0, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (wr_n !== 0) begin n_fail++; $display("FAIL pre31_write: got %0d want 0", wr_n); end
    run_frame(32, 2'b11, 5'd1, REG_ID1, 16'h0000, 1'b0, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (oe_err !== 0) begin n_fail++; $display("FAIL op11_drive: got %0d driven samples want 0", oe_err); end
    run_frame(32, 2'b00, 5'd1, 5'd7, 16'h5A5A, 1'b0, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (wr_n !== 0) begin n_fail++; $display("FAIL op00_write: got %0d want 0", wr_n); end
    run_frame(45, OP_READ, 5'd1, REG_ID2, 16'h0, 1'b1, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (rd !== m_read(REG_ID2) || oe_err !== 0) begin n_fail++; $display("FAIL pre45_read: got %h/%0d want %h/0", rd, oe_err, m_read(REG_ID2)); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, d;
    logic ta;
    int oe_err, wr_n, soft_n;
    d = 16'($urandom);
    run_frame(32, OP_WRITE, 5'd1, 5'd31, d, 1'b0, -1, rd, ta, oe_err, wr_n, soft_n);
    m_write(5'd31, d);
    run_frame(32, OP_READ, 5'd1, 5'd31, 16'h0, 1'b1, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (rd !== m_read(5'd31) || oe_err !== 0) begin n_fail++; $display("FAIL b2b_rd31: got %h/%0d want %h/0", rd, oe_err, m_read(5'd31)); end
    run_frame(32, OP_READ, 5'd1, REG_ID2, 16'h0, 1'b1, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (rd !== m_read(REG_ID2) || ta !== 1'b0) begin n_fail++; $display("FAIL b2b_id2: got %h ta %b want %h ta 0", rd, ta, m_read(REG_ID2)); end
  endtask

  task automatic test_random();
    logic [15:0] rd, exp, d;
    logic [1:0]  op;
    logic [4:0]  pa, ra;
    logic ta;
    bit   hit, drive, do_wr;
    int   oe_err, wr_n, soft_n, sel, pre;
    for (int it = 0; it < 24; it++) begin
      status_i = 16'($urandom);
      sel = $urandom_range(0, 9);
      op = (sel < 5) ? OP_READ : (sel < 9) ? OP_WRITE : ($urandom_range(0, 1) ? 2'b11 : 2'b00);
      if ($urandom_range(0, 3) == 0) begin
        pa = 5'($urandom_range(0, 30));
        if (pa >= 5'd1) pa = pa + 5'd1;
      end else begin
        pa = 5'd1;
      end
      ra = 5'($urandom);
      d = 16'($urandom);
      pre = $urandom_range(32, 40);
      hit = (pa == 5'd1);
      drive = hit && (op == OP_READ);
      do_wr = hit && (op == OP_WRITE);
      exp = m_read(ra);
      run_frame(pre, op, pa, ra, d, drive, -1, rd, ta, oe_err, wr_n, soft_n);
      if (do_wr) m_write(ra, d);
      n_cmp++; if (oe_err !== 0) begin n_fail++; $display("FAIL rnd%0d_oe: got %0d bad samples want 0 (op %b pa %0d)", it, oe_err, op, pa); end
      if (drive) begin
        n_cmp++; if (rd !== exp || ta !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_read: reg %0d got %h ta %b want %h ta 0", it, ra, rd, ta, exp); end
      end
      n_cmp++; if (wr_n !== (do_wr ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_wr_pulse: got %0d want %0d", it, wr_n, do_wr ? 1 : 0); end
      if (do_wr) begin
        n_cmp++; if (last_wr_addr !== ra || last_wr_data !== d) begin n_fail++; $display("FAIL rnd%0d_wr_strobe: got %0d/%h want %0d/%h", it, last_wr_addr, last_wr_data, ra, d); end
      end
      n_cmp++; if (soft_n !== ((do_wr && ra == 5'd0 && d[15]) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_soft: got %0d", it, soft_n); end
      n_cmp++; if (ctrl_o !== m_ctrl) begin n_fail++; $display("FAIL rnd%0d_ctrl: got %h want %h", it, ctrl_o, m_ctrl); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] rd;
    logic ta;
    int oe_err, wr_n, soft_n;
    run_frame(32, OP_WRITE, 5'd1, 5'd6, 16'h1111, 1'b0, -1, rd, ta, oe_err, wr_n, soft_n);
    m_write(5'd6, 16'h1111);
    // Stop right after the rise where the station samples D7 (index pre+25).
    run_frame(32, OP_READ, 5'd1, REG_ID1, 16'h0, 1'b1, 32 + 26, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (oe_mdio !== 1'b1) begin n_fail++; $display("FAIL mid_read_driving: got %b want 1", oe_mdio); end
    rst = 1'b1;
    @(negedge clk_rmii);
    n_cmp++; if (oe_mdio !== 1'b0 || o_mdio !== 1'b0) begin n_fail++; $display("FAIL mid_rst_release: got oe %b o %b want 0 0", oe_mdio, o_mdio); end
    i_mdc = 1'b0;
    repeat (3) @(negedge clk_rmii);
    rst = 1'b0;
    m_reset();
    @(negedge clk_rmii);
    status_i = 16'($urandom);
    run_frame(32, OP_READ, 5'd1, REG_STAT, 16'h0, 1'b1, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (rd !== m_read(REG_STAT) || oe_err !== 0) begin n_fail++; $display("FAIL post_rst_status: got %h/%0d want %h/0", rd, oe_err, m_read(REG_STAT)); end
    run_frame(32, OP_READ, 5'd1, 5'd6, 16'h0, 1'b1, -1, rd, ta, oe_err, wr_n, soft_n);
    n_cmp++; if (rd !== m_read(5'd6)) begin n_fail++; $display("FAIL post_rst_store_cleared: got %h want %h", rd, m_read(5'd6)); end
  endtask

  initial begin
    rst = 1'b1;
    i_mdc = 1'b0;
    i_mdio = 1'b1;
    status_i = 16'h0;
    m_reset();
    test_reset();
    test_read_id();
    test_write_read();
    test_soft_reset();
    test_wrong_phyad();
    test_bad_frames();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
